mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Memory stage of the RISC-V pipeline; consumes the execute stage's record: ALU result as the address, rs2 data, mem op/sel, and the writeback controls.
- Runs loads and stores on a single-outstanding valid/ready data bus.
- Aligns store data, generates byte enables, and extracts/extends load data.
- Presents a registered record to the writeback stage with a valid/ready handshake.

Parameters:
- BUS_TIMEOUT, 255: cycles waited in REQ+RSP before aborting with bus_error. 0 disables the watchdog.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  execute record valid
- in_ready  out  1  stage can accept a record
- alu_result  in  32  address, or the result passed through
- rs2_data  in  32  store data
- mem_op  in  2  00 none, 01 load, 10 store, 11 treated as none
- mem_sel  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- rd_in  in  5  destination register
- reg_we_in  in  1  register write enable
- wb_sel_in  in  2  writeback mux select
- pc_adder_result_in  in  32  pc+4 / link value
- out_valid  out  1  writeback record valid
- out_ready  in  1  writeback accepts
- mem_rdata_out  out  32  extended load data (0 for non-loads)
- alu_result_out, rd_out, reg_we_out, wb_sel_out, pc_adder_result_out  out  32/5/1/2/32  captured copies
- bus_req_valid  out  1;  bus_req_ready  in  1
- bus_req_we  out  1;  bus_req_addr  out  32 (word aligned);  bus_req_wdata  out  32;  bus_req_be  out  4
- bus_rsp_valid  in  1;  bus_rsp_rdata  in  32
- bus_error  out  1  record aborted by timeout
- misalign_fault  out  1  record misaligned (tied 0 without the macro)

Behaviour:
- Reset: state IDLE. All outputs and captured registers are 0; in_ready is 1 after reset.
  - Reset mid-transaction abandons the transaction; bus_req_valid is 0 after the edge.
  - A stale bus_rsp_valid arriving in IDLE is ignored.
- FSM states: IDLE, REQ, RSP, HOLD.
- IDLE: in_ready=1. On in_valid, capture all inputs.
  - mem_op none → HOLD. out_valid is asserted the cycle after capture (latency 1).
  - Load or store → REQ.
- REQ: bus_req_valid=1; all req fields stay stable until bus_req_ready. The handshake moves to RSP. A bus_rsp_valid seen in REQ is ignored.
- RSP: waits for bus_rsp_valid, for both loads and stores.
  - Load: mem_rdata_out is latched from the extracted lane.
  - Store: mem_rdata_out stays 0.
  - Then → HOLD.
- Watchdog: counter cleared on entering REQ, counts each cycle in REQ/RSP.
  - When it reaches BUS_TIMEOUT: bus_req_valid=0, bus_error=1, mem_rdata_out=0, reg_we_out forced 0, → HOLD.
- HOLD: out_valid=1 and in_ready=0. On out_ready → IDLE, clearing bus_error and misalign_fault.
  - Throughput: minimum 2 cycles per record.
- Address: bus_req_addr={alu_result[31:2],2'b00}.
- Stores:
  - SB: be=4'b0001<<a[1:0], wdata={4{rs2[7:0]}}
  - SH: be=4'b0011<<{a[1],1'b0}, wdata={2{rs2[15:0]}}
  - SW: be=4'b1111, wdata=rs2
- Loads:
  - Byte lane a[1:0], halfword lane a[1].
  - 000/001 sign-extend; 100/101 zero-extend; 010 full word.
  - Loads drive bus_req_be=1111 and wdata=0.
- Unlisted mem_sel codes (011,110,111) behave as W.
- Misalignment without the macro: halfword with a[0]=1 uses lane a[1]; word ignores a[1:0].

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined: a halfword with a[0]≠0, or a word with a[1:0]≠0, skips the bus and goes IDLE→HOLD.
  - misalign_fault=1, reg_we_out=0, mem_rdata_out=0.
- Undefined: misalign_fault tied 0; misaligned accesses are truncated as described above.

Decomposition:
- Shared package holds:
  - MEM_OP_NONE/LOAD/STORE constants.
  - mem_sel funct3 codes (MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU).
  - FSM state encoding.
- One combinational sub-module, mem_lane_align: store be/wdata generation and load extraction/extension. It is reusable by a future cache.

Test Plan:
- ALU-only record, alu_result=0x1234, mem_op=00 → out_valid one cycle later; alu_result_out=0x1234; mem_rdata_out=0; no bus_req_valid.
- SB addr 0x1003, rs2=0xAABBCCDD → bus_req_addr=0x1000, be=1000, wdata=0xDDDDDDDD, we=1. Holds while bus_req_ready=0 for 3 cycles.
- LB addr 0x2002, rsp_rdata=0x00800000 → mem_rdata_out=0xFFFFFF80. Same access with LBU → 0x00000080.
- LH addr 0x3002, rsp_rdata=0x8001FFFF → 0xFFFF8001. With out_ready=0 for 4 cycles the record holds and in_ready=0.
- BUS_TIMEOUT=8, bus_req_ready stuck 0 → after 8 cycles bus_error=1 and reg_we_out=0 in HOLD. A later stray bus_rsp_valid is ignored.
- MEM_MISALIGN_TRAP_EN defined, LW addr 0x4001 → no bus request, misalign_fault=1 next cycle. Reset asserted while in RSP → IDLE, all outputs 0 on the next edge.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared constants for the memory stage: mem_op codes, funct3 access sizes, FSM states.
package mem_access_stage_pkg;

   localparam logic [1:0] MEM_OP_NONE  = 2'b00;
   localparam logic [1:0] MEM_OP_LOAD  = 2'b01;
   localparam logic [1:0] MEM_OP_STORE = 2'b10;

   localparam logic [2:0] MEM_B  = 3'b000;
   localparam logic [2:0] MEM_H  = 3'b001;
   localparam logic [2:0] MEM_W  = 3'b010;
   localparam logic [2:0] MEM_BU = 3'b100;
   localparam logic [2:0] MEM_HU = 3'b101;

   typedef enum logic [1:0] {IDLE, REQ, RSP, HOLD} state_e;
   typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

   // funct3[1:0] carries the size; codes 011/110/111 fall through to word.
   function automatic size_e sel_size(input logic [2:0] sel);
      case (sel[1:0])
         2'b00:   return SZ_BYTE;
         2'b01:   return SZ_HALF;
         default: return SZ_WORD;
      endcase
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store byte enables / replicated write data, and
// load lane extraction with sign or zero extension.
module mem_lane_align
   import mem_access_stage_pkg::*;
(
   input  logic [2:0]  sel_i,
   input  logic [1:0]  addr_lo_i,
   input  logic        is_store_i,
   input  logic [31:0] store_data_i,
   input  logic [31:0] load_word_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] load_data_o
);

   logic [7:0]  lbyte;
   logic [15:0] lhalf;

   always_comb begin
      be_o    = 4'b1111;
      wdata_o = '0;
      if (is_store_i) begin
         case (sel_size(sel_i))
            SZ_BYTE: begin
               be_o    = 4'b0001 << addr_lo_i;
               wdata_o = {4{store_data_i[7:0]}};
            end
            SZ_HALF: begin
               be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
               wdata_o = {2{store_data_i[15:0]}};
            end
            default: wdata_o = store_data_i;
         endcase
      end
   end

   // funct3[2] selects zero extension for the byte/half forms.
   always_comb begin
      lbyte = 8'(load_word_i >> {addr_lo_i, 3'b000});
      lhalf = addr_lo_i[1] ? load_word_i[31:16] : load_word_i[15:0];
      case (sel_size(sel_i))
         SZ_BYTE: load_data_o = sel_i[2] ? {24'b0, lbyte} : {{24{lbyte[7]}}, lbyte};
         SZ_HALF: load_data_o = sel_i[2] ? {16'b0, lhalf} : {{16{lhalf[15]}}, lhalf};
         default: load_data_o = load_word_i;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// RISC-V memory stage: single-outstanding bus access with watchdog, registered WB record.
// Optional MEM_MISALIGN_TRAP_EN: misaligned half/word accesses skip the bus and flag misalign_fault.
module mem_access_stage
   import mem_access_stage_pkg::*;
#(
   parameter int unsigned BUS_TIMEOUT = 255
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] alu_result,
   input  logic [31:0] rs2_data,
   input  logic [1:0]  mem_op,
   input  logic [2:0]  mem_sel,
   input  logic [4:0]  rd_in,
   input  logic        reg_we_in,
   input  logic [1:0]  wb_sel_in,
   input  logic [31:0] pc_adder_result_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] mem_rdata_out,
   output logic [31:0] alu_result_out,
   output logic [4:0]  rd_out,
   output logic        reg_we_out,
   output logic [1:0]  wb_sel_out,
   output logic [31:0] pc_adder_result_out,
   output logic        bus_req_valid,
   input  logic        bus_req_ready,
   output logic        bus_req_we,
   output logic [31:0] bus_req_addr,
   output logic [31:0] bus_req_wdata,
   output logic [3:0]  bus_req_be,
   input  logic        bus_rsp_valid,
   input  logic [31:0] bus_rsp_rdata,
   output logic        bus_error,
   output logic        misalign_fault
);

   state_e      state_q;
   logic [31:0] addr_q, rs2_q, pc_q, rdata_q, wd_q;
   logic [1:0]  op_q, wbsel_q;
   logic [2:0]  sel_q;
   logic [4:0]  rd_q;
   logic        we_q, err_q, mis_q;

   logic [3:0]  be;
   logic [31:0] wdata, load_ext;
   logic        is_mem_in, misaligned_in, timeout, in_req;

   mem_lane_align u_align (
      .sel_i        (sel_q),
      .addr_lo_i    (addr_q[1:0]),
      .is_store_i   (op_q == MEM_OP_STORE),
      .store_data_i (rs2_q),
      .load_word_i  (bus_rsp_rdata),
      .be_o         (be),
      .wdata_o      (wdata),
      .load_data_o  (load_ext)
   );

   assign is_mem_in = (mem_op == MEM_OP_LOAD) || (mem_op == MEM_OP_STORE);

`ifdef MEM_MISALIGN_TRAP_EN
   always_comb begin
      case (sel_size(mem_sel))
         SZ_HALF: misaligned_in = alu_result[0];
         SZ_WORD: misaligned_in = |alu_result[1:0];
         default: misaligned_in = 1'b0;
      endcase
   end
`else
   assign misaligned_in = 1'b0;
`endif

   // wd_q counts cycles already spent in REQ/RSP; abort on the last allowed one.
   assign timeout = (BUS_TIMEOUT != 0) && (wd_q == 32'(BUS_TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         rs2_q   <= '0;
         pc_q    <= '0;
         rdata_q <= '0;
         wd_q    <= '0;
         op_q    <= '0;
         wbsel_q <= '0;
         sel_q   <= '0;
         rd_q    <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (in_valid) begin
               addr_q  <= alu_result;
               rs2_q   <= rs2_data;
               pc_q    <= pc_adder_result_in;
               op_q    <= mem_op;
               sel_q   <= mem_sel;
               rd_q    <= rd_in;
               wbsel_q <= wb_sel_in;
               rdata_q <= '0;
               wd_q    <= '0;
               err_q   <= 1'b0;
               mis_q   <= is_mem_in && misaligned_in;
               we_q    <= reg_we_in && !(is_mem_in && misaligned_in);
               state_q <= (is_mem_in && !misaligned_in) ? REQ : HOLD;
            end
            REQ: begin
               wd_q <= wd_q + 32'd1;
               if (bus_req_ready) state_q <= RSP;
               else if (timeout) begin
                  err_q   <= 1'b1;
                  we_q    <= 1'b0;
                  rdata_q <= '0;
                  state_q <= HOLD;
               end
            end
            RSP: begin
               wd_q <= wd_q + 32'd1;
               if (bus_rsp_valid) begin
                  if (op_q == MEM_OP_LOAD) rdata_q <= load_ext;
                  state_q <= HOLD;
               end else if (timeout) begin
                  err_q   <= 1'b1;
                  we_q    <= 1'b0;
                  rdata_q <= '0;
                  state_q <= HOLD;
               end
            end
            HOLD: if (out_ready) begin
               err_q   <= 1'b0;
               mis_q   <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign in_req              = (state_q == REQ);
   assign in_ready            = (state_q == IDLE);
   assign out_valid           = (state_q == HOLD);
   assign bus_req_valid       = in_req;
   assign bus_req_we          = in_req && (op_q == MEM_OP_STORE);
   assign bus_req_addr        = in_req ? {addr_q[31:2], 2'b00} : '0;
   assign bus_req_wdata       = in_req ? wdata : '0;
   assign bus_req_be          = in_req ? be : '0;
   assign mem_rdata_out       = rdata_q;
   assign alu_result_out      = addr_q;
   assign rd_out              = rd_q;
   assign reg_we_out          = we_q;
   assign wb_sel_out          = wbsel_q;
   assign pc_adder_result_out = pc_q;
   assign bus_error           = err_q;
   assign misalign_fault      = mis_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage (BUS_TIMEOUT=8); honours MEM_MISALIGN_TRAP_EN when defined.
module tb_mem_access_stage;
   import mem_access_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, reg_we_in, out_valid, out_ready, reg_we_out;
   logic [31:0] alu_result, rs2_data, pc_adder_result_in, mem_rdata_out, alu_result_out;
   logic [31:0] pc_adder_result_out, bus_req_addr, bus_req_wdata, bus_rsp_rdata;
   logic [1:0]  mem_op, wb_sel_in, wb_sel_out;
   logic [2:0]  mem_sel;
   logic [4:0]  rd_in, rd_out;
   logic        bus_req_valid, bus_req_ready, bus_req_we, bus_rsp_valid, bus_error, misalign_fault;
   logic [3:0]  bus_req_be;
   int          checks = 0, errors = 0;

   mem_access_stage #(.BUS_TIMEOUT(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .alu_result(alu_result), .rs2_data(rs2_data), .mem_op(mem_op), .mem_sel(mem_sel),
      .rd_in(rd_in), .reg_we_in(reg_we_in), .wb_sel_in(wb_sel_in),
      .pc_adder_result_in(pc_adder_result_in), .out_valid(out_valid), .out_ready(out_ready),
      .mem_rdata_out(mem_rdata_out), .alu_result_out(alu_result_out), .rd_out(rd_out),
      .reg_we_out(reg_we_out), .wb_sel_out(wb_sel_out), .pc_adder_result_out(pc_adder_result_out),
      .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_we(bus_req_we),
      .bus_req_addr(bus_req_addr), .bus_req_wdata(bus_req_wdata), .bus_req_be(bus_req_be),
      .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata),
      .bus_error(bus_error), .misalign_fault(misalign_fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] op, input logic [2:0] sel, input logic [31:0] a,
                       input logic [31:0] d, input logic we);
      in_valid = 1'b1; mem_op = op; mem_sel = sel; alu_result = a; rs2_data = d;
      reg_we_in = we; rd_in = 5'd7; wb_sel_in = 2'd1; pc_adder_result_in = a + 32'd4;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   // From REQ: accept the request, then return one response.
   task automatic complete(input logic [31:0] rdata);
      bus_req_ready = 1'b1;
      tick();
      bus_req_ready = 1'b0;
      bus_rsp_valid = 1'b1; bus_rsp_rdata = rdata;
      tick();
      bus_rsp_valid = 1'b0;
   endtask

   task automatic do_load(input string tag, input logic [2:0] sel, input logic [31:0] a,
                          input logic [31:0] rdata, input logic [31:0] exp);
      logic [31:0] wa;
      wa = {a[31:2], 2'b00};
      send(MEM_OP_LOAD, sel, a, 32'hFFFF_FFFF, 1'b1);
      chk({tag, " addr"}, bus_req_addr, wa);
      chk({tag, " be"}, bus_req_be, 32'hF);
      chk({tag, " wdata"}, bus_req_wdata, 32'h0);
      chk({tag, " we"}, bus_req_we, 32'h0);
      complete(rdata);
      chk({tag, " data"}, mem_rdata_out, exp);
      chk({tag, " regwe"}, reg_we_out, 32'h1);
      drain();
   endtask

   initial begin
      int n;
      rst = 1'b1; in_valid = 0; mem_op = 0; mem_sel = 0; alu_result = 0; rs2_data = 0;
      rd_in = 0; reg_we_in = 0; wb_sel_in = 0; pc_adder_result_in = 0; out_ready = 0;
      bus_req_ready = 0; bus_rsp_valid = 0; bus_rsp_rdata = 0;
      tick(); tick();
      rst = 1'b0;
      chk("rst in_ready", in_ready, 32'h1);
      chk("rst out_valid", out_valid, 32'h0);
      chk("rst req_valid", bus_req_valid, 32'h0);
      chk("rst alu_out", alu_result_out, 32'h0);
      chk("rst be", bus_req_be, 32'h0);

      // ALU-only record
      send(MEM_OP_NONE, MEM_W, 32'h1234, 32'h0, 1'b1);
      chk("alu out_valid", out_valid, 32'h1);
      chk("alu result", alu_result_out, 32'h1234);
      chk("alu rdata", mem_rdata_out, 32'h0);
      chk("alu req_valid", bus_req_valid, 32'h0);
      chk("alu pc", pc_adder_result_out, 32'h1238);
      chk("alu rd", rd_out, 32'd7);
      chk("alu regwe", reg_we_out, 32'h1);
      drain();
      chk("alu drained", out_valid, 32'h0);

      // SB with backpressure; a response during REQ must be ignored
      send(MEM_OP_STORE, MEM_B, 32'h1003, 32'hAABBCCDD, 1'b0);
      for (int i = 0; i < 3; i++) begin
         bus_rsp_valid = (i == 1);
         chk("sb valid", bus_req_valid, 32'h1);
         chk("sb addr", bus_req_addr, 32'h1000);
         chk("sb be", bus_req_be, 32'h8);
         chk("sb wdata", bus_req_wdata, 32'hDDDDDDDD);
         chk("sb we", bus_req_we, 32'h1);
         tick();
      end
      bus_rsp_valid = 1'b0;
      chk("sb still req", bus_req_valid, 32'h1);
      complete(32'h1234_5678);
      chk("sb out_valid", out_valid, 32'h1);
      chk("sb rdata", mem_rdata_out, 32'h0);
      drain();

      send(MEM_OP_STORE, MEM_H, 32'h1002, 32'h1234ABCD, 1'b0);
      chk("sh be", bus_req_be, 32'hC);
      chk("sh wdata", bus_req_wdata, 32'hABCDABCD);
      complete(32'h0);
      drain();
      send(MEM_OP_STORE, MEM_W, 32'h1000, 32'h1234ABCD, 1'b0);
      chk("sw be", bus_req_be, 32'hF);
      chk("sw wdata", bus_req_wdata, 32'h1234ABCD);
      complete(32'h0);
      drain();

      do_load("lb", MEM_B, 32'h2002, 32'h00800000, 32'hFFFFFF80);
      do_load("lbu", MEM_BU, 32'h2002, 32'h00800000, 32'h00000080);
      do_load("lhu", MEM_HU, 32'h3000, 32'h8001FFFF, 32'h0000FFFF);
      do_load("lw", MEM_W, 32'h3004, 32'hCAFEF00D, 32'hCAFEF00D);

      // LH with writeback stall
      send(MEM_OP_LOAD, MEM_H, 32'h3002, 32'h0, 1'b1);
      complete(32'h8001FFFF);
      for (int i = 0; i < 4; i++) begin
         chk("lh hold valid", out_valid, 32'h1);
         chk("lh hold in_ready", in_ready, 32'h0);
         chk("lh data", mem_rdata_out, 32'hFFFF8001);
         tick();
      end
      drain();
      chk("lh released", in_ready, 32'h1);

      // Watchdog: request never accepted
      send(MEM_OP_LOAD, MEM_W, 32'h5000, 32'h0, 1'b1);
      n = 0;
      for (int i = 0; i < 20 && bus_req_valid; i++) begin
         n++;
         tick();
      end
      chk("to cycles", n, 32'd8);
      chk("to bus_error", bus_error, 32'h1);
      chk("to regwe", reg_we_out, 32'h0);
      chk("to out_valid", out_valid, 32'h1);
      chk("to rdata", mem_rdata_out, 32'h0);
      drain();
      chk("to err clear", bus_error, 32'h0);
      bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'hDEADBEEF;
      tick();
      bus_rsp_valid = 1'b0;
      chk("stray in_ready", in_ready, 32'h1);
      chk("stray out_valid", out_valid, 32'h0);
      chk("stray req", bus_req_valid, 32'h0);

      // Misaligned word
      send(MEM_OP_LOAD, MEM_W, 32'h4001, 32'h0, 1'b1);
`ifdef MEM_MISALIGN_TRAP_EN
      chk("mis req", bus_req_valid, 32'h0);
      chk("mis fault", misalign_fault, 32'h1);
      chk("mis out_valid", out_valid, 32'h1);
      chk("mis regwe", reg_we_out, 32'h0);
      chk("mis rdata", mem_rdata_out, 32'h0);
      drain();
      chk("mis clear", misalign_fault, 32'h0);
`else
      chk("mis req", bus_req_valid, 32'h1);
      chk("mis addr", bus_req_addr, 32'h4000);
      complete(32'h11223344);
      chk("mis rdata", mem_rdata_out, 32'h11223344);
      chk("mis fault", misalign_fault, 32'h0);
      drain();
`endif

      // Reset while waiting in RSP
      send(MEM_OP_LOAD, MEM_W, 32'h6000, 32'h0, 1'b1);
      bus_req_ready = 1'b1;
      tick();
      bus_req_ready = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rsprst req", bus_req_valid, 32'h0);
      chk("rsprst in_ready", in_ready, 32'h1);
      chk("rsprst out_valid", out_valid, 32'h0);
      chk("rsprst alu", alu_result_out, 32'h0);
      chk("rsprst regwe", reg_we_out, 32'h0);
      chk("rsprst rd", rd_out, 32'h0);
      bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h55AA55AA;
      tick();
      bus_rsp_valid = 1'b0;
      chk("rsprst stale", out_valid, 32'h0);
      chk("rsprst rdata", mem_rdata_out, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
